// File: rtl/counter.sv
// Modulo-(MAX_COUNT+1) up/down counter that supplies the sequence index to the
// parent's prime/Fibonacci decoder. The count is always registered; reset is synchronous and active-low.
module counter #(
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             updown,
  input  logic             enable,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_next;
  logic [WIDTH-1:0] w_count_inc;
  logic [WIDTH-1:0] w_count_dec;
  logic             w_at_max;
  logic             w_at_zero;
  logic             w_illegal;

  assign w_at_max    = (r_count == LP_MAX);
  assign w_at_zero   = (r_count == LP_ZERO);
  assign w_illegal   = (r_count > LP_MAX);
  assign w_count_inc = w_at_max  ? LP_ZERO : (r_count + LP_ONE);
  assign w_count_dec = w_at_zero ? LP_MAX  : (r_count - LP_ONE);

  // An out-of-range count is recovered to 0 on the next enabled step,
  // regardless of the direction. While the counter is disabled, that value is held.
  always_comb begin
    w_count_next = r_count;
    if (enable) begin
      if (w_illegal) begin
        w_count_next = LP_ZERO;
      end else if (updown) begin
        w_count_next = w_count_inc;
      end else begin
        w_count_next = w_count_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= LP_ZERO;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign q = r_count;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: a directed vector table, hand-written multi-cycle
// corner cases, and randomized stimulus checked against a modulo-arithmetic model.
module tb_counter;

  localparam int WIDTH     = 4;
  localparam int MAX_COUNT = 10;
  localparam int NSTATES   = MAX_COUNT + 1;

  logic             clk;
  logic             reset;
  logic             updown;
  logic             enable;
  logic [WIDTH-1:0] q;

  int n_total;
  int n_pass;

  typedef struct {
    logic rst_n;
    logic en;
    logic up;
    int   exp_q;
    string tag;
  } vec_t;

  vec_t vecs[$];

  counter #(.WIDTH(WIDTH), .MAX_COUNT(MAX_COUNT)) dut (
    .clk    (clk),
    .reset  (reset),
    .updown (updown),
    .enable (enable),
    .q      (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
      $display("ok   %s: q=%0d", name, act);
    end else begin
      $display("FAIL %s: q=%0d expected %0d", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; q is sampled 1ns after the rising edge.
  task automatic step(input logic r, input logic e, input logic u);
    @(negedge clk);
    reset  = r;
    enable = e;
    updown = u;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input logic r, input logic e, input logic u,
                              input int exp, input string tag);
    vec_t v;
    v.rst_n = r; v.en = e; v.up = u; v.exp_q = exp; v.tag = tag;
    vecs.push_back(v);
  endfunction

  initial begin
    int model;
    n_total = 0;
    n_pass  = 0;
    reset   = 1'b0;
    enable  = 1'b0;
    updown  = 1'b0;

    step(1'b0, 1'b0, 1'b0);
    check("reset_state", int'(q), 0);

    // The vector table is applied in order, and each expected value follows from the previous row.
    add(1, 1, 1, 1, "pre_up");
    add(1, 1, 1, 2, "pre_up");
    add(1, 1, 1, 3, "pre_up");
    for (int i = 0; i < 3; i++) add(0, 1, 1, 0, "reset_hold");
    add(1, 0, 1, 0, "release_disabled");
    for (int i = 1; i <= 12; i++) add(1, 1, 1, i % NSTATES, "up_wrap");
    add(0, 0, 0, 0, "reset");
    add(1, 1, 0, 10, "down_wrap");
    add(1, 1, 0, 9, "down");
    add(1, 1, 0, 8, "down");
    add(0, 0, 0, 0, "reset");
    for (int i = 1; i <= 6; i++) add(1, 1, 1, i, "count_to_6");
    for (int i = 0; i < 5; i++) add(1, 0, i[0], 6, "hold");
    add(1, 1, 1, 7, "reenable");
    add(0, 0, 0, 0, "reset");
    for (int i = 1; i <= 5; i++) add(1, 1, 1, i, "count_to_5");
    add(1, 1, 0, 4, "dir_down");
    add(1, 1, 0, 3, "dir_down");
    add(1, 1, 1, 4, "dir_up");

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].up);
      check($sformatf("vec%0d_%s", i, vecs[i].tag), int'(q), vecs[i].exp_q);
    end

    // Reset asserted between edges has no effect until the next rising edge.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b1);
    check("pre_midreset", int'(q), 8);
    @(negedge clk);
    reset = 1'b0;
    #2;
    check("midreset_before_edge", int'(q), 8);
    @(posedge clk);
    #1;
    check("midreset_after_edge", int'(q), 0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("reset_beats_down", int'(q), 0);
    end
    step(1'b1, 1'b1, 1'b0);
    check("resume_down", int'(q), MAX_COUNT);

    // The reference model is the count reduced modulo the number of states.
    model = MAX_COUNT;
    for (int i = 0; i < 200; i++) begin
      logic r, e, u;
      r = ($urandom_range(0, 9) != 0);
      e = ($urandom_range(0, 3) != 0);
      u = $urandom_range(0, 1) == 1;
      step(r, e, u);
      if (!r)      model = 0;
      else if (e)  model = u ? (model + 1) % NSTATES : (model + NSTATES - 1) % NSTATES;
      check($sformatf("rand%0d r=%0d e=%0d u=%0d", i, r, e, u), int'(q), model);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
